control_cronometru: RTL and testbench

- Stopwatch/time-of-day controller built around chained modulo counters: seconds 0-59, minutes 0-59, hours 0..HOUR_MAX-1.
- A mode FSM sequences the chain: idle, running, paused, and manual set of minutes and hours.
- Clocked by the slow clk_out_led tick; one count per clock edge in RUN.
- Sits between debounced button pulses and the 7-segment/LED display driver.

---
 rtl/control_cronometru.sv | 177 +++++++++++++++++
 tb/tb_control_cronometru.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/control_cronometru.sv
// control_cronometru: stopwatch / time-of-day controller with chained sec/min/hour
// counters, a run/pause/set mode FSM and a blink phase for the field being edited.
// Revision 1.0
`default_nettype none

module control_cronometru #(
  parameter int HOUR_MAX  = 24,
  parameter int BLINK_DIV = 2
) (
  input  logic       clk_out_led,
  input  logic       reset,
  input  logic       btn_start_stop,
  input  logic       btn_clear,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [5:0] sec,
  output logic [5:0] min,
  output logic [4:0] hour,
  output logic       running,
  output logic [1:0] setting,
  output logic       blink,
  output logic       day_wrap
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_RUN      = 3'd1;
  localparam logic [2:0] S_PAUSED   = 3'd2;
  localparam logic [2:0] S_SET_MIN  = 3'd3;
  localparam logic [2:0] S_SET_HOUR = 3'd4;

  localparam logic [5:0] SIXTY_LAST = 6'd59;
  localparam logic [4:0] HOUR_LAST  = 5'(HOUR_MAX - 1);
  localparam int         DIV_W      = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BLINK_DIV - 1);

  logic [2:0]       state_q, state_d;
  logic [5:0]       sec_q, sec_d;
  logic [5:0]       min_q, min_d;
  logic [4:0]       hour_q, hour_d;
  logic             running_q;
  logic [1:0]       setting_q, setting_d;
  logic             blink_q, blink_d;
  logic             wrap_q, wrap_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             count;
  logic             in_set_d;

  // Only the highest-priority pressed button survives; the others are dropped.
  logic clr_eff, mode_eff, ss_eff, inc_eff;
  assign clr_eff  = btn_clear;
  assign mode_eff = btn_mode & ~btn_clear;
  assign ss_eff   = btn_start_stop & ~btn_clear & ~btn_mode;
  assign inc_eff  = btn_inc & ~btn_clear & ~btn_mode & ~btn_start_stop;

  always_comb begin
    state_d = state_q;
    sec_d   = sec_q;
    min_d   = min_q;
    hour_d  = hour_q;
    wrap_d  = 1'b0;
    count   = 1'b0;

    if (clr_eff) begin
      state_d = S_IDLE;
      sec_d   = '0;
      min_d   = '0;
      hour_d  = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (mode_eff) begin
            state_d = S_SET_MIN;
            sec_d   = '0;
          end else if (ss_eff) begin
            state_d = S_RUN;
          end
        end
        S_RUN: begin
          if (ss_eff) state_d = S_PAUSED;
          else        count   = 1'b1;
        end
        S_PAUSED: begin
          if (mode_eff) begin
            state_d = S_SET_MIN;
            sec_d   = '0;
          end else if (ss_eff) begin
            state_d = S_RUN;
          end
        end
        S_SET_MIN: begin
          if (mode_eff)     state_d = S_SET_HOUR;
          else if (ss_eff)  state_d = S_RUN;
          else if (inc_eff) min_d   = (min_q == SIXTY_LAST) ? 6'd0 : min_q + 6'd1;
        end
        S_SET_HOUR: begin
          if (mode_eff)     state_d = S_PAUSED;
          else if (ss_eff)  state_d = S_RUN;
          else if (inc_eff) hour_d  = (hour_q == HOUR_LAST) ? 5'd0 : hour_q + 5'd1;
        end
        default: state_d = S_IDLE;
      endcase
    end

    if (count) begin
      if (sec_q == SIXTY_LAST) begin
        sec_d = '0;
        if (min_q == SIXTY_LAST) begin
          min_d = '0;
          if (hour_q == HOUR_LAST) begin
            hour_d = '0;
            wrap_d = 1'b1;
          end else begin
            hour_d = hour_q + 5'd1;
          end
        end else begin
          min_d = min_q + 6'd1;
        end
      end else begin
        sec_d = sec_q + 6'd1;
      end
    end
  end

  always_comb begin
    in_set_d  = (state_d == S_SET_MIN) || (state_d == S_SET_HOUR);
    setting_d = (state_d == S_SET_MIN)  ? 2'b01 :
                (state_d == S_SET_HOUR) ? 2'b10 : 2'b00;
    div_d     = '0;
    blink_d   = 1'b0;
    // Any entry into a set state (including min -> hour) restarts the blink phase at 1.
    if (in_set_d) begin
      if (state_d != state_q) begin
        blink_d = 1'b1;
      end else if (div_q == DIV_LAST) begin
        blink_d = ~blink_q;
      end else begin
        div_d   = div_q + 1'b1;
        blink_d = blink_q;
      end
    end
  end

  always_ff @(posedge clk_out_led) begin
    if (reset) begin
      state_q   <= S_IDLE;
      sec_q     <= '0;
      min_q     <= '0;
      hour_q    <= '0;
      running_q <= 1'b0;
      setting_q <= 2'b00;
      blink_q   <= 1'b0;
      wrap_q    <= 1'b0;
      div_q     <= '0;
    end else begin
      state_q   <= state_d;
      sec_q     <= sec_d;
      min_q     <= min_d;
      hour_q    <= hour_d;
      running_q <= (state_d == S_RUN);
      setting_q <= setting_d;
      blink_q   <= blink_d;
      wrap_q    <= wrap_d;
      div_q     <= div_d;
    end
  end

  assign sec      = sec_q;
  assign min      = min_q;
  assign hour     = hour_q;
  assign running  = running_q;
  assign setting  = setting_q;
  assign blink    = blink_q;
  assign day_wrap = wrap_q;

endmodule

`default_nettype wire

// File: tb/tb_control_cronometru.sv
// Bench for control_cronometru: directed scenarios plus random button traffic,
// compared every edge against a time-in-seconds reference model.
`default_nettype none

module tb_control_cronometru;

  localparam int HOUR_MAX  = 24;
  localparam int BLINK_DIV = 2;
  localparam int DAY       = HOUR_MAX * 3600;

  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_SETMIN = 3, M_SETHOUR = 4;

  logic       clk_out_led = 1'b0;
  logic       reset = 1'b0;
  logic       btn_start_stop = 1'b0, btn_clear = 1'b0, btn_mode = 1'b0, btn_inc = 1'b0;
  logic [5:0] sec, min;
  logic [4:0] hour;
  logic       running, blink, day_wrap;
  logic [1:0] setting;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model: elapsed time of day in seconds, mode, edges since entering a set mode
  int m_st, m_t, m_since;
  bit m_blink, m_wrap;

  control_cronometru #(.HOUR_MAX(HOUR_MAX), .BLINK_DIV(BLINK_DIV)) dut (
    .clk_out_led   (clk_out_led),
    .reset         (reset),
    .btn_start_stop(btn_start_stop),
    .btn_clear     (btn_clear),
    .btn_mode      (btn_mode),
    .btn_inc       (btn_inc),
    .sec           (sec),
    .min           (min),
    .hour          (hour),
    .running       (running),
    .setting       (setting),
    .blink         (blink),
    .day_wrap      (day_wrap)
  );

  always #5 clk_out_led = ~clk_out_led;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge(input bit r, input bit ss, input bit clr, input bit md, input bit inc);
    int prev, f;
    prev   = m_st;
    m_wrap = 1'b0;
    if (r) begin
      m_st = M_IDLE; m_t = 0;
    end else if (clr) begin
      m_st = M_IDLE; m_t = 0;
    end else if (md) begin
      case (m_st)
        M_IDLE, M_PAUSED: begin m_st = M_SETMIN; m_t = m_t - (m_t % 60); end
        M_SETMIN:  m_st = M_SETHOUR;
        M_SETHOUR: m_st = M_PAUSED;
        default: ;
      endcase
      if (prev == M_RUN) begin
        if (m_t == DAY - 1) begin m_t = 0; m_wrap = 1'b1; end
        else m_t = m_t + 1;
      end
    end else if (ss) begin
      m_st = (m_st == M_RUN) ? M_PAUSED : M_RUN;
    end else begin
      if (m_st == M_RUN) begin
        if (m_t == DAY - 1) begin m_t = 0; m_wrap = 1'b1; end
        else m_t = m_t + 1;
      end else if (inc && m_st == M_SETMIN) begin
        f   = (m_t / 60) % 60;
        m_t = m_t - f * 60 + ((f + 1) % 60) * 60;
      end else if (inc && m_st == M_SETHOUR) begin
        f   = m_t / 3600;
        m_t = m_t - f * 3600 + ((f + 1) % HOUR_MAX) * 3600;
      end
    end
    if (m_st == M_SETMIN || m_st == M_SETHOUR) begin
      m_since = (m_st != prev) ? 0 : m_since + 1;
      m_blink = ((m_since / BLINK_DIV) % 2) == 0;
    end else begin
      m_since = 0;
      m_blink = 1'b0;
    end
  endtask

  task automatic compare_all();
    check("sec",      32'(sec),      32'(m_t % 60));
    check("min",      32'(min),      32'((m_t / 60) % 60));
    check("hour",     32'(hour),     32'(m_t / 3600));
    check("running",  32'(running),  32'(m_st == M_RUN));
    check("setting",  32'(setting),  (m_st == M_SETMIN) ? 32'd1 : (m_st == M_SETHOUR) ? 32'd2 : 32'd0);
    check("blink",    32'(blink),    32'(m_blink));
    check("day_wrap", 32'(day_wrap), 32'(m_wrap));
  endtask

  task automatic step(input bit r, input bit ss, input bit clr, input bit md, input bit inc);
    @(negedge clk_out_led);
    reset = r; btn_start_stop = ss; btn_clear = clr; btn_mode = md; btn_inc = inc;
    @(posedge clk_out_led);
    #1;
    reset = 1'b0; btn_start_stop = 1'b0; btn_clear = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0;
    model_edge(r, ss, clr, md, inc);
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask

  bit wrap_seen;
  bit pat[5];

  initial begin
    // reset state
    step(1, 0, 0, 0, 0);
    check("rst_sec", 32'(sec), 0);
    check("rst_running", 32'(running), 0);

    // run count: 61 edges after start -> 00:01:01
    step(0, 1, 0, 0, 0);
    wrap_seen = 1'b0;
    for (int i = 0; i < 61; i++) begin
      step(0, 0, 0, 0, 0);
      wrap_seen |= day_wrap;
    end
    check("run_sec", 32'(sec), 1);
    check("run_min", 32'(min), 1);
    check("run_hour", 32'(hour), 0);
    check("run_running", 32'(running), 1);
    check("run_nowrap", 32'(wrap_seen), 0);

    // pause hold
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    idle(10);
    step(0, 1, 0, 0, 0);
    idle(20);
    check("pause_sec", 32'(sec), 10);
    check("pause_running", 32'(running), 0);
    step(0, 1, 0, 0, 0);
    idle(1);
    check("resume_sec", 32'(sec), 11);

    // set 23:59 and roll over the day
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    for (int i = 0; i < 59; i++) step(0, 0, 0, 0, 1);
    check("set_min59", 32'(min), 59);
    check("set_hour0", 32'(hour), 0);
    step(0, 0, 0, 1, 0);
    for (int i = 0; i < 23; i++) step(0, 0, 0, 0, 1);
    check("set_hour23", 32'(hour), 23);
    step(0, 1, 0, 0, 0);
    idle(59);
    check("prewrap_sec", 32'(sec), 59);
    check("prewrap_dw", 32'(day_wrap), 0);
    idle(1);
    check("wrap_hour", 32'(hour), 0);
    check("wrap_min", 32'(min), 0);
    check("wrap_sec", 32'(sec), 0);
    check("wrap_dw", 32'(day_wrap), 1);
    idle(1);
    check("wrap_dw_clear", 32'(day_wrap), 0);

    // manual minute wrap does not carry into hour
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    for (int i = 0; i < 60; i++) step(0, 0, 0, 0, 1);
    check("minwrap_min", 32'(min), 0);
    check("minwrap_hour", 32'(hour), 0);

    // simultaneous clear+start_stop+mode in RUN
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    idle(5);
    check("sim_pre_sec", 32'(sec), 5);
    step(0, 1, 1, 1, 0);
    check("sim_sec", 32'(sec), 0);
    check("sim_running", 32'(running), 0);
    check("sim_setting", 32'(setting), 0);

    // reset in SET_HOUR at hour 7
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    for (int i = 0; i < 7; i++) step(0, 0, 0, 0, 1);
    idle(3);
    check("rmid_hour7", 32'(hour), 7);
    step(1, 0, 0, 0, 0);
    check("rmid_hour", 32'(hour), 0);
    check("rmid_setting", 32'(setting), 0);
    check("rmid_blink", 32'(blink), 0);
    step(0, 0, 0, 0, 1);
    check("rmid_inc", 32'(hour), 0);
    step(0, 1, 0, 0, 0);
    idle(1);
    check("rmid_count", 32'(sec), 1);

    // blink pattern after entering SET_MIN
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    check("blink_enter", 32'(blink), 1);
    check("blink_setting", 32'(setting), 1);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 0, 0);
      pat[i] = blink;
    end
    check("blink_p0", 32'(pat[0]), 1);
    check("blink_p1", 32'(pat[1]), 0);
    check("blink_p2", 32'(pat[2]), 0);
    check("blink_p3", 32'(pat[3]), 1);
    check("blink_p4", 32'(pat[4]), 1);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    check("blink_paused", 32'(blink), 0);
    check("paused_setting", 32'(setting), 0);
    check("paused_running", 32'(running), 0);

    // random traffic against the model
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      bit r, ss, clr, md, inc;
      r   = ($urandom_range(0, 199) == 0);
      clr = ($urandom_range(0, 59) == 0);
      md  = ($urandom_range(0, 9) == 0);
      ss  = ($urandom_range(0, 11) == 0);
      inc = ($urandom_range(0, 2) == 0);
      step(r, ss, clr, md, inc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
